// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction field positions and the HALT opcode.
package ifetch_unit_pkg;

  // FSM state encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_VALID = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  // Instruction field positions (msb/lsb)
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int IMM_MSB = 2;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_HALT = 4'hF;

  // Opcode field of an instruction word
  function automatic logic [3:0] get_opcode(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  // Immediate field of an instruction word
  function automatic logic [2:0] get_imm3(input logic [15:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: requests words from instruction memory, holds one
// instruction for decode, and handles redirects, flushes and HALT.
// Latency: id_valid rises the cycle after imem_ack; outputs are Moore.
// Backpressure: the held instruction stays stable while id_ready is low.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [15:0] id_instr,
  output logic [7:0]  id_pc,
  output logic [2:0]  id_imm3,
  input  logic        redirect,
  input  logic [7:0]  redirect_target,
  output logic        halted
);

  logic [2:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  req_addr_q, req_addr_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  id_pc_q, id_pc_d;

  // Next-state logic for the FSM, PC, request address and instruction register
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ir_d       = ir_q;
    id_pc_d    = id_pc_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redirect) begin
          pc_d       = redirect_target;
          req_addr_d = redirect_target;
        end
      end
      S_FETCH: begin
        if (redirect && imem_ack) begin
          // Returning word belongs to the old path: drop it, refetch at target
          pc_d       = redirect_target;
          req_addr_d = redirect_target;
        end else if (redirect) begin
          // Request still in flight: keep it stable, remember where to go next
          pc_d    = redirect_target;
          state_d = S_FLUSH;
        end else if (imem_ack) begin
          ir_d    = imem_rdata;
          id_pc_d = req_addr_q;
          pc_d    = req_addr_q + 8'd1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (redirect) begin
          pc_d       = redirect_target;
          req_addr_d = redirect_target;
          state_d    = S_FETCH;
        end else if (id_ready) begin
          if (get_opcode(ir_q) == OP_HALT) begin
            state_d = S_HALT;
          end else begin
            req_addr_d = pc_q;
            state_d    = S_FETCH;
          end
        end
      end
      S_FLUSH: begin
        if (redirect) begin
          pc_d = redirect_target;
        end
        if (imem_ack) begin
          // Stale word discarded; next request goes to the latest target
          req_addr_d = pc_d;
          state_d    = S_FETCH;
        end
      end
      S_HALT: begin
        if (redirect) begin
          pc_d       = redirect_target;
          req_addr_d = redirect_target;
          state_d    = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ir_q       <= 16'h0000;
      id_pc_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ir_q       <= ir_d;
      id_pc_q    <= id_pc_d;
    end
  end

  // Moore outputs decoded from registers only
  always_comb begin
    imem_req  = (state_q == S_FETCH) || (state_q == S_FLUSH);
    imem_addr = req_addr_q;
    id_valid  = (state_q == S_VALID);
    halted    = (state_q == S_HALT);
    id_instr  = ir_q;
    id_pc     = id_pc_q;
    id_imm3   = get_imm3(ir_q);
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit against a transaction-level model of the
// fetch rules (outstanding request, dropped response, held instruction, halt).
// Runs with RESET_PC=8'hFF so the address wrap is exercised after each reset.
module tb_ifetch_unit;

  localparam logic [7:0] RST_PC = 8'hFF;
  localparam int N_CYCLES = 4000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic [2:0]  id_imm3;
  logic        redirect;
  logic [7:0]  redirect_target;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [256];

  // Reference model state
  bit         m_started;   // left IDLE
  bit         m_req;       // a memory request is outstanding
  bit         m_drop;      // the outstanding response must be discarded
  bit         m_valid;     // an instruction is offered to decode
  bit         m_halt;
  logic [7:0] m_pc, m_addr, m_ipc;
  logic [15:0] m_instr;

  ifetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_imm3(id_imm3),
    .redirect(redirect), .redirect_target(redirect_target),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_req     = 1'b0;
    m_drop    = 1'b0;
    m_valid   = 1'b0;
    m_halt    = 1'b0;
    m_pc      = RST_PC;
    m_addr    = RST_PC;
    m_ipc     = 8'h00;
    m_instr   = 16'h0000;
  endtask

  // One clock of the fetch rules, using the inputs present at the edge
  task automatic model_step();
    if (!m_started) begin
      m_started = 1'b1;
      m_req     = 1'b1;
      if (redirect) begin
        m_pc   = redirect_target;
        m_addr = redirect_target;
      end
    end else if (m_halt) begin
      if (redirect) begin
        m_halt = 1'b0;
        m_req  = 1'b1;
        m_pc   = redirect_target;
        m_addr = redirect_target;
      end
    end else if (m_req) begin
      if (imem_ack) begin
        if (m_drop || redirect) begin
          if (redirect) m_pc = redirect_target;
          m_drop = 1'b0;
          m_addr = m_pc;
        end else begin
          m_instr = imem_rdata;
          m_ipc   = m_addr;
          m_pc    = m_addr + 8'd1;
          m_req   = 1'b0;
          m_valid = 1'b1;
        end
      end else if (redirect) begin
        m_pc   = redirect_target;
        m_drop = 1'b1;
      end
    end else if (m_valid) begin
      if (redirect) begin
        m_valid = 1'b0;
        m_req   = 1'b1;
        m_pc    = redirect_target;
        m_addr  = redirect_target;
      end else if (id_ready) begin
        m_valid = 1'b0;
        if (m_instr[15:12] == 4'hF) begin
          m_halt = 1'b1;
        end else begin
          m_req  = 1'b1;
          m_addr = m_pc;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("imem_req",  {31'd0, imem_req}, {31'd0, m_req});
    check("imem_addr", {24'd0, imem_addr}, {24'd0, m_addr});
    check("id_valid",  {31'd0, id_valid}, {31'd0, m_valid});
    check("halted",    {31'd0, halted},   {31'd0, m_halt});
    check("id_instr",  {16'd0, id_instr}, {16'd0, m_instr});
    check("id_pc",     {24'd0, id_pc},    {24'd0, m_ipc});
    check("id_imm3",   {29'd0, id_imm3},  {29'd0, m_instr[2:0]});
  endtask

  // Pick inputs for the next edge; memory answers the model's request
  task automatic drive_inputs(input int since_rst);
    bit quiet;
    quiet    = (since_rst < 12);
    id_ready = ($urandom_range(0, 2) != 0);
    redirect = quiet ? 1'b0 : ($urandom_range(0, 7) == 0);
    redirect_target = 8'($urandom);
    if (m_req) begin
      imem_ack   = ($urandom_range(0, 2) == 0);
      imem_rdata = mem[m_addr];
    end else begin
      imem_ack   = ($urandom_range(0, 3) == 0);
      imem_rdata = 16'($urandom);
    end
  endtask

  initial begin
    int since_rst;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'hFF] = 16'h1235;
    mem[8'h00] = 16'h2346;
    mem[8'h01] = 16'h3457;

    reset_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    id_ready = 1'b0;
    redirect = 1'b0;
    redirect_target = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;
    since_rst = 0;
    drive_inputs(since_rst);

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      since_rst++;
      if (since_rst > 600 && m_req) begin
        // Abandon an in-flight request with an asynchronous reset
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_req_drop", {31'd0, imem_req}, 32'd0);
        check("async_valid_drop", {31'd0, id_valid}, 32'd0);
        @(posedge clk);
        #1;
        compare_all();
        reset_n = 1'b1;
        since_rst = 0;
      end
      drive_inputs(since_rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
